// File: rtl/vram_fill_arbiter.sv
// vram_fill_arbiter: rectangle-fill blitter sharing the VRAM write port with the CPU, which always wins.
module vram_fill_arbiter #(
    parameter int SCR_W = 200,
    parameter int SCR_H = 150
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_we_i,
    input  logic [14:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        fill_start_i,
    input  logic [7:0]  fill_x_i,
    input  logic [7:0]  fill_y_i,
    input  logic [7:0]  fill_w_i,
    input  logic [7:0]  fill_h_i,
    input  logic [7:0]  fill_color_i,
    output logic        fill_busy_o,
    output logic        fill_done_o,
    output logic        v_we_o,
    output logic [14:0] v_addr_o,
    output logic [7:0]  v_data_o
);
    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;
    localparam logic [8:0] W9 = 9'(SCR_W);
    localparam logic [8:0] H9 = 9'(SCR_H);
    state_t state;
    logic [7:0] x, y, w, h, color;
    logic [8:0] x_end, y_end, col, row, x_sum, y_sum;
    logic [14:0] row_base;
    logic run_wr;
    assign x_sum = {1'b0, x} + {1'b0, w};
    assign y_sum = {1'b0, y} + {1'b0, h};
    assign run_wr = state == RUN && !cpu_we_i;
    assign fill_busy_o = state != IDLE;
    assign fill_done_o = state == DONE;
    assign v_we_o = cpu_we_i | run_wr;
    assign v_addr_o = run_wr ? row_base + 15'(col) : cpu_addr_i;
    assign v_data_o = run_wr ? color : cpu_data_i;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x <= '0;
            y <= '0;
            w <= '0;
            h <= '0;
            color <= '0;
            x_end <= '0;
            y_end <= '0;
            col <= '0;
            row <= '0;
            row_base <= '0;
        end else begin
            case (state)
                IDLE: if (fill_start_i) begin
                    state <= SETUP;
                    x <= fill_x_i;
                    y <= fill_y_i;
                    w <= fill_w_i;
                    h <= fill_h_i;
                    color <= fill_color_i;
                end
                SETUP: begin
                    x_end <= x_sum < W9 ? x_sum : W9;
                    y_end <= y_sum < H9 ? y_sum : H9;
                    col <= {1'b0, x};
                    row <= {1'b0, y};
                    row_base <= 15'(y) * 15'(SCR_W);
                    state <= (w == 8'd0 || h == 8'd0 || {1'b0, x} >= W9 || {1'b0, y} >= H9) ? DONE : RUN;
                end
                RUN: if (!cpu_we_i) begin
                    if (col == x_end - 9'd1) begin
                        col <= {1'b0, x};
                        if (row == y_end - 9'd1) begin
                            state <= DONE;
                        end else begin
                            row <= row + 9'd1;
                            row_base <= row_base + 15'(SCR_W);
                        end
                    end else begin
                        col <= col + 9'd1;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule
